// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory and
// writeback over 2-5 cycles per instruction. Memory waits use mem_ready. Interrupts
// are taken only at instruction boundaries. Undefined encodings can trap to the
// illegal-instruction vector.
module multicycle_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1,  // 1: FETCH/MEM wait for mem_ready
   parameter bit IRQ_ENABLE    = 1'b1,  // 0: irq is ignored entirely
   parameter bit ILLOP_TRAP    = 1'b1   // 0: undefined ops retire as a NOP after DECODE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       irq,
   input  logic       kernel,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [2:0] PCSrc,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       ALUSrc1,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       ExtOp,
   output logic       LuOp,
   output logic       instr_done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_IRQ    = 3'd5,
      S_EXC    = 3'd6
   } state_t;

   // All datapath controls are bundled so that one reset gate covers them.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [2:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src1;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       done;
   } ctrl_t;

   state_t cur, nxt;
   ctrl_t  ctl, ctl_o;

   logic r_legal, i_legal, legal;
   logic is_rtype, is_j, is_jal, is_jr, is_jalr, is_branch, is_lw, is_sw;
   logic mem_ok, take_irq, zero_ext;
   state_t end_next;

   // Legal R-type function codes
   always_comb begin
      r_legal = 1'b0;
      case (Funct)
         6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2a, 6'h2b: r_legal = 1'b1;
         default:      r_legal = 1'b0;
      endcase
   end

   // Legal non-R-type opcodes (jumps, branches, I-type ALU, load/store)
   always_comb begin
      i_legal = 1'b0;
      case (OpCode)
         6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f,
         6'h23, 6'h2b: i_legal = 1'b1;
         default:      i_legal = 1'b0;
      endcase
   end

   // Immediate extension: logical ops and the unsigned forms zero-extend
   always_comb begin
      zero_ext = 1'b0;
      case (OpCode)
         6'h09, 6'h0b, 6'h0c, 6'h0d: zero_ext = 1'b1;
         default:                    zero_ext = 1'b0;
      endcase
   end

   assign is_rtype  = (OpCode == 6'h00);
   assign is_j      = (OpCode == 6'h02);
   assign is_jal    = (OpCode == 6'h03);
   assign is_jr     = is_rtype && (Funct == 6'h08);
   assign is_jalr   = is_rtype && (Funct == 6'h09);
   assign is_branch = (OpCode == 6'h01) || ((OpCode >= 6'h04) && (OpCode <= 6'h07));
   assign is_lw     = (OpCode == 6'h23);
   assign is_sw     = (OpCode == 6'h2b);
   assign legal     = is_rtype ? r_legal : i_legal;

   // Without the handshake, memory is treated as always completing in one cycle.
   assign mem_ok   = MEM_HANDSHAKE ? mem_ready : 1'b1;
   // irq is looked at only when an instruction retires.
   assign take_irq = IRQ_ENABLE && irq && !kernel;
   assign end_next = take_irq ? S_IRQ : S_FETCH;

   // State register; reset always returns to FETCH
   always_ff @(posedge clk) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   // Next-state and control decode for each state
   always_comb begin
      nxt = cur;
      ctl = '0;
      case (cur)
         S_FETCH: begin
            // Read the instruction and compute PC+4. Commit both only when the read completes.
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.ir_write  = mem_ok;
            ctl.pc_write  = mem_ok;
            if (mem_ok) nxt = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is precomputed here while the register file is read.
            ctl.alu_src_b = 2'b11;
            if (is_j) begin
               ctl.pc_write = 1'b1;
               ctl.pc_src   = 3'b010;
               ctl.done     = 1'b1;
               nxt          = end_next;
            end else if (is_jal) begin
               nxt = S_WB;
            end else if (legal) begin
               nxt = S_EXEC;
            end else if (ILLOP_TRAP) begin
               nxt = S_EXC;
            end else begin
               ctl.done = 1'b1;
               nxt      = end_next;
            end
         end
         S_EXEC: begin
            ctl.alu_src_a = 1'b1;
            if (is_rtype) begin
               ctl.alu_src_b = 2'b00;
               ctl.alu_op    = 2'b10;
               ctl.alu_src1  = (Funct <= 6'h03);  // shifts take shamt as operand 1
               if (is_jr) begin
                  ctl.pc_write = 1'b1;
                  ctl.pc_src   = 3'b011;
                  ctl.done     = 1'b1;
                  nxt          = end_next;
               end else begin
                  nxt = S_WB;
               end
            end else if (is_branch) begin
               ctl.alu_src_b     = 2'b00;
               ctl.alu_op        = 2'b01;
               ctl.pc_write_cond = 1'b1;
               ctl.pc_src        = 3'b001;
               ctl.done          = 1'b1;
               nxt               = end_next;
            end else if (is_lw || is_sw) begin
               ctl.alu_src_b = 2'b10;
               ctl.alu_op    = 2'b00;
               nxt           = S_MEM;
            end else begin
               ctl.alu_src_b = 2'b10;
               ctl.alu_op    = 2'b11;
               nxt           = S_WB;
            end
         end
         S_MEM: begin
            // The strobe is held until the access completes.
            ctl.iord      = 1'b1;
            ctl.mem_read  = is_lw;
            ctl.mem_write = is_sw;
            if (mem_ok) begin
               if (is_lw) begin
                  nxt = S_WB;
               end else begin
                  ctl.done = 1'b1;
                  nxt      = end_next;
               end
            end
         end
         S_WB: begin
            ctl.reg_write = 1'b1;
            ctl.done      = 1'b1;
            nxt           = end_next;
            if (is_jal) begin
               ctl.reg_dst    = 2'b10;
               ctl.mem_to_reg = 2'b10;
               ctl.pc_write   = 1'b1;
               ctl.pc_src     = 3'b010;
            end else if (is_jalr) begin
               ctl.reg_dst    = 2'b01;
               ctl.mem_to_reg = 2'b10;
               ctl.pc_write   = 1'b1;
               ctl.pc_src     = 3'b011;
            end else if (is_rtype) begin
               ctl.reg_dst = 2'b01;
            end else if (is_lw) begin
               ctl.mem_to_reg = 2'b01;
            end
         end
         S_IRQ, S_EXC: begin
            // PC already holds the next instruction address. Save it in $26 and vector.
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = 2'b11;
            ctl.mem_to_reg = 2'b10;
            ctl.pc_write   = 1'b1;
            ctl.pc_src     = (cur == S_IRQ) ? 3'b101 : 3'b100;
            ctl.done       = 1'b1;
            nxt            = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
   end

   // Reset forces every output low, including the write strobes of an in-flight access.
   assign ctl_o       = reset ? '0 : ctl;
   assign PCWrite     = ctl_o.pc_write;
   assign PCWriteCond = ctl_o.pc_write_cond;
   assign PCSrc       = ctl_o.pc_src;
   assign IorD        = ctl_o.iord;
   assign MemRead     = ctl_o.mem_read;
   assign MemWrite    = ctl_o.mem_write;
   assign IRWrite     = ctl_o.ir_write;
   assign RegWrite    = ctl_o.reg_write;
   assign RegDst      = ctl_o.reg_dst;
   assign MemToReg    = ctl_o.mem_to_reg;
   assign ALUSrc1     = ctl_o.alu_src1;
   assign ALUSrcA     = ctl_o.alu_src_a;
   assign ALUSrcB     = ctl_o.alu_src_b;
   assign ALUOp       = ctl_o.alu_op;
   assign instr_done  = ctl_o.done;
   assign ExtOp       = !reset && !zero_ext;
   assign LuOp        = !reset && (OpCode == 6'h0f);
   assign state       = reset ? 3'd0 : cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller. Each queue entry holds one cycle
// of stimulus and the expected controls for that cycle. Bits outside an entry's mask are
// don't-care. Instance a uses the default parameters. Instance b uses no handshake, no irq
// and no illegal-op trap.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic reset, irq, kernel, mem_ready;
   logic [5:0] OpCode, Funct;

   logic a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_RegWrite;
   logic a_ALUSrc1, a_ALUSrcA, a_ExtOp, a_LuOp, a_instr_done;
   logic [2:0] a_PCSrc, a_state;
   logic [1:0] a_RegDst, a_MemToReg, a_ALUSrcB, a_ALUOp;
   logic b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_RegWrite;
   logic b_ALUSrc1, b_ALUSrcA, b_ExtOp, b_LuOp, b_instr_done;
   logic [2:0] b_PCSrc, b_state;
   logic [1:0] b_RegDst, b_MemToReg, b_ALUSrcB, b_ALUOp;

   multicycle_controller dut_a (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .irq(irq), .kernel(kernel),
      .mem_ready(mem_ready), .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCSrc(a_PCSrc),
      .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
      .RegWrite(a_RegWrite), .RegDst(a_RegDst), .MemToReg(a_MemToReg), .ALUSrc1(a_ALUSrc1),
      .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .ExtOp(a_ExtOp),
      .LuOp(a_LuOp), .instr_done(a_instr_done), .state(a_state));

   multicycle_controller #(.MEM_HANDSHAKE(1'b0), .IRQ_ENABLE(1'b0), .ILLOP_TRAP(1'b0)) dut_b (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .irq(irq), .kernel(kernel),
      .mem_ready(mem_ready), .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .PCSrc(b_PCSrc),
      .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
      .RegWrite(b_RegWrite), .RegDst(b_RegDst), .MemToReg(b_MemToReg), .ALUSrc1(b_ALUSrc1),
      .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .ExtOp(b_ExtOp),
      .LuOp(b_LuOp), .instr_done(b_instr_done), .state(b_state));

   always #5 clk = ~clk;

   // Field positions in the packed observation vector
   localparam int F_PCW = 25, F_PCC = 24, F_PCSRC = 21, F_IORD = 20, F_MR = 19, F_MW = 18;
   localparam int F_IRW = 17, F_RW = 16, F_RDST = 14, F_MTR = 12, F_AS1 = 11, F_ASA = 10;
   localparam int F_ASB = 8, F_AOP = 6, F_EXT = 5, F_LU = 4, F_DONE = 3, F_ST = 0;

   logic [25:0] obs_a, obs_b;
   assign obs_a = {a_PCWrite, a_PCWriteCond, a_PCSrc, a_IorD, a_MemRead, a_MemWrite, a_IRWrite,
                   a_RegWrite, a_RegDst, a_MemToReg, a_ALUSrc1, a_ALUSrcA, a_ALUSrcB, a_ALUOp,
                   a_ExtOp, a_LuOp, a_instr_done, a_state};
   assign obs_b = {b_PCWrite, b_PCWriteCond, b_PCSrc, b_IorD, b_MemRead, b_MemWrite, b_IRWrite,
                   b_RegWrite, b_RegDst, b_MemToReg, b_ALUSrc1, b_ALUSrcA, b_ALUSrcB, b_ALUOp,
                   b_ExtOp, b_LuOp, b_instr_done, b_state};

   typedef struct {
      logic        rst, rdy, irq, kern, sel;
      logic [5:0]  op, fn;
      logic [25:0] val, msk;
      string       tag;
   } ent_t;

   ent_t q[$];
   int checks = 0;
   int errors = 0;
   logic       cur_sel = 1'b0;
   logic [5:0] cur_op = 6'h00, cur_fn = 6'h00;

   function automatic ent_t put(ent_t e, int lo, int w, logic [2:0] v);
      for (int i = 0; i < w; i++) begin
         e.val[lo+i] = v[i];
         e.msk[lo+i] = 1'b1;
      end
      return e;
   endfunction

   // Common part: the write strobes, instr_done and state are checked in every cycle.
   function automatic ent_t base(string tag, logic [2:0] st, logic done);
      ent_t e;
      e.tag = tag; e.val = '0; e.msk = '0;
      e.rst = 1'b0; e.rdy = 1'b1; e.irq = 1'b0; e.kern = 1'b0;
      e.sel = cur_sel; e.op = cur_op; e.fn = cur_fn;
      e = put(e, F_PCW, 1, 3'd0);
      e = put(e, F_PCC, 1, 3'd0);
      e = put(e, F_MR, 1, 3'd0);
      e = put(e, F_MW, 1, 3'd0);
      e = put(e, F_IRW, 1, 3'd0);
      e = put(e, F_RW, 1, 3'd0);
      e = put(e, F_DONE, 1, 3'(done));
      e = put(e, F_ST, 3, st);
      return e;
   endfunction

   function automatic ent_t e_rst(string tag);
      ent_t e = base(tag, 3'd0, 1'b0);
      e.rst = 1'b1;
      e.msk = '1;
      e.val = '0;
      return e;
   endfunction

   function automatic ent_t e_fetch(string tag, logic rdy);
      ent_t e = base(tag, 3'd0, 1'b0);
      e.rdy = rdy;
      e = put(e, F_MR, 1, 3'd1);
      e = put(e, F_IORD, 1, 3'd0);
      e = put(e, F_ASA, 1, 3'd0);
      e = put(e, F_ASB, 2, 3'd1);
      e = put(e, F_AOP, 2, 3'd0);
      e = put(e, F_PCSRC, 3, 3'd0);
      e = put(e, F_IRW, 1, 3'(rdy));
      e = put(e, F_PCW, 1, 3'(rdy));
      return e;
   endfunction

   function automatic ent_t e_dec(string tag, logic done);
      ent_t e = base(tag, 3'd1, done);
      e = put(e, F_ASB, 2, 3'd3);
      return e;
   endfunction

   function automatic ent_t e_exr(string tag, logic sh, logic done);
      ent_t e = base(tag, 3'd2, done);
      e = put(e, F_ASA, 1, 3'd1);
      e = put(e, F_ASB, 2, 3'd0);
      e = put(e, F_AOP, 2, 3'd2);
      e = put(e, F_AS1, 1, 3'(sh));
      return e;
   endfunction

   function automatic ent_t e_exi(string tag, logic [2:0] aop);
      ent_t e = base(tag, 3'd2, 1'b0);
      e = put(e, F_ASB, 2, 3'd2);
      e = put(e, F_AOP, 2, aop);
      return e;
   endfunction

   function automatic ent_t e_exbr(string tag);
      ent_t e = base(tag, 3'd2, 1'b1);
      e = put(e, F_AOP, 2, 3'd1);
      e = put(e, F_PCC, 1, 3'd1);
      e = put(e, F_PCSRC, 3, 3'd1);
      return e;
   endfunction

   function automatic ent_t e_mem(string tag, logic wr, logic rdy, logic done);
      ent_t e = base(tag, 3'd3, done);
      e.rdy = rdy;
      e = put(e, F_IORD, 1, 3'd1);
      e = put(e, F_MR, 1, 3'(!wr));
      e = put(e, F_MW, 1, 3'(wr));
      return e;
   endfunction

   function automatic ent_t e_wb(string tag, logic [2:0] dst, logic [2:0] mtr);
      ent_t e = base(tag, 3'd4, 1'b1);
      e = put(e, F_RW, 1, 3'd1);
      e = put(e, F_RDST, 2, dst);
      e = put(e, F_MTR, 2, mtr);
      return e;
   endfunction

   function automatic ent_t e_trap(string tag, logic [2:0] st, logic [2:0] src);
      ent_t e = base(tag, st, 1'b1);
      e = put(e, F_RW, 1, 3'd1);
      e = put(e, F_RDST, 2, 3'd3);
      e = put(e, F_MTR, 2, 3'd2);
      e = put(e, F_PCW, 1, 3'd1);
      e = put(e, F_PCSRC, 3, src);
      return e;
   endfunction

   function automatic ent_t pcw(ent_t e, logic [2:0] src);
      e = put(e, F_PCW, 1, 3'd1);
      e = put(e, F_PCSRC, 3, src);
      return e;
   endfunction

   // Drain the queue: drive each entry just after a falling edge, compare 1 ns later.
   task automatic run();
      ent_t e;
      logic [25:0] o;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clk);
         reset = e.rst; mem_ready = e.rdy; irq = e.irq; kernel = e.kern;
         OpCode = e.op; Funct = e.fn;
         #1;
         o = e.sel ? obs_b : obs_a;
         checks++;
         assert ((o & e.msk) === (e.val & e.msk)) else begin
            errors++;
            $error("FAIL %s observed %h expected %h mask %h", e.tag, o & e.msk, e.val & e.msk, e.msk);
         end
      end
   endtask

   initial begin
      ent_t e;
      reset = 1'b1; irq = 1'b0; kernel = 1'b0; mem_ready = 1'b0; OpCode = 6'h23; Funct = 6'h00;

      // Instance a: reset cycles
      cur_sel = 1'b0; cur_op = 6'h23;
      q.push_back(e_rst("rst0")); q.push_back(e_rst("rst1"));
      run();

      // add: 4 cycles
      cur_op = 6'h00; cur_fn = 6'h20;
      q.push_back(e_fetch("add.F", 1'b1)); q.push_back(e_dec("add.D", 1'b0));
      q.push_back(e_exr("add.E", 1'b0, 1'b0)); q.push_back(e_wb("add.WB", 3'd1, 3'd0));
      // sll after two fetch wait cycles; shamt operand selected
      cur_fn = 6'h00;
      q.push_back(e_fetch("sll.Fw0", 1'b0)); q.push_back(e_fetch("sll.Fw1", 1'b0));
      q.push_back(e_fetch("sll.F", 1'b1)); q.push_back(e_dec("sll.D", 1'b0));
      q.push_back(e_exr("sll.E", 1'b1, 1'b0)); q.push_back(e_wb("sll.WB", 3'd1, 3'd0));
      // lw with three MEM wait cycles: 8 cycles total
      cur_op = 6'h23;
      q.push_back(e_fetch("lw.F", 1'b1));
      e = e_dec("lw.D", 1'b0); e = put(e, F_EXT, 1, 3'd1); e = put(e, F_LU, 1, 3'd0); q.push_back(e);
      q.push_back(e_exi("lw.E", 3'd0));
      q.push_back(e_mem("lw.Mw0", 1'b0, 1'b0, 1'b0)); q.push_back(e_mem("lw.Mw1", 1'b0, 1'b0, 1'b0));
      q.push_back(e_mem("lw.Mw2", 1'b0, 1'b0, 1'b0)); q.push_back(e_mem("lw.M", 1'b0, 1'b1, 1'b0));
      q.push_back(e_wb("lw.WB", 3'd0, 3'd1));
      // sw: ends in MEM
      cur_op = 6'h2b;
      q.push_back(e_fetch("sw.F", 1'b1)); q.push_back(e_dec("sw.D", 1'b0));
      q.push_back(e_exi("sw.E", 3'd0));
      q.push_back(e_mem("sw.Mw", 1'b1, 1'b0, 1'b0)); q.push_back(e_mem("sw.M", 1'b1, 1'b1, 1'b1));
      run();

      // beq with irq seen at its last cycle: IRQ state follows
      cur_op = 6'h04;
      q.push_back(e_fetch("beq.F", 1'b1)); q.push_back(e_dec("beq.D", 1'b0));
      e = e_exbr("beq.E"); e.irq = 1'b1; q.push_back(e);
      q.push_back(e_trap("irq", 3'd5, 3'd5));
      // bne with irq but kernel mode: no IRQ state
      cur_op = 6'h05;
      q.push_back(e_fetch("bne.F", 1'b1)); q.push_back(e_dec("bne.D", 1'b0));
      e = e_exbr("bne.E"); e.irq = 1'b1; e.kern = 1'b1; q.push_back(e);
      // illegal opcode 0x3f traps
      cur_op = 6'h3f;
      q.push_back(e_fetch("ill.F", 1'b1)); q.push_back(e_dec("ill.D", 1'b0));
      q.push_back(e_trap("ill.EXC", 3'd6, 3'd4));
      // illegal R-type funct 0x01 traps
      cur_op = 6'h00; cur_fn = 6'h01;
      q.push_back(e_fetch("illr.F", 1'b1)); q.push_back(e_dec("illr.D", 1'b0));
      q.push_back(e_trap("illr.EXC", 3'd6, 3'd4));
      run();

      // jal: 3 cycles
      cur_op = 6'h03; cur_fn = 6'h00;
      q.push_back(e_fetch("jal.F", 1'b1)); q.push_back(e_dec("jal.D", 1'b0));
      q.push_back(pcw(e_wb("jal.WB", 3'd2, 3'd2), 3'd2));
      // j: 2 cycles
      cur_op = 6'h02;
      q.push_back(e_fetch("j.F", 1'b1)); q.push_back(pcw(e_dec("j.D", 1'b1), 3'd2));
      // jr: 3 cycles
      cur_op = 6'h00; cur_fn = 6'h08;
      q.push_back(e_fetch("jr.F", 1'b1)); q.push_back(e_dec("jr.D", 1'b0));
      q.push_back(pcw(e_exr("jr.E", 1'b0, 1'b1), 3'd3));
      // jalr: 4 cycles
      cur_fn = 6'h09;
      q.push_back(e_fetch("jalr.F", 1'b1)); q.push_back(e_dec("jalr.D", 1'b0));
      q.push_back(e_exr("jalr.E", 1'b0, 1'b0));
      q.push_back(pcw(e_wb("jalr.WB", 3'd1, 3'd2), 3'd3));
      // ori: zero-extended immediate
      cur_op = 6'h0d; cur_fn = 6'h00;
      q.push_back(e_fetch("ori.F", 1'b1));
      e = e_dec("ori.D", 1'b0); e = put(e, F_EXT, 1, 3'd0); e = put(e, F_LU, 1, 3'd0); q.push_back(e);
      q.push_back(e_exi("ori.E", 3'd3)); q.push_back(e_wb("ori.WB", 3'd0, 3'd0));
      // lui
      cur_op = 6'h0f;
      q.push_back(e_fetch("lui.F", 1'b1));
      e = e_dec("lui.D", 1'b0); e = put(e, F_EXT, 1, 3'd1); e = put(e, F_LU, 1, 3'd1); q.push_back(e);
      q.push_back(e_exi("lui.E", 3'd3)); q.push_back(e_wb("lui.WB", 3'd0, 3'd0));
      run();

      // Reset during a stalled lw MEM, then during a stalled sw MEM
      cur_op = 6'h23;
      q.push_back(e_fetch("rlw.F", 1'b1)); q.push_back(e_dec("rlw.D", 1'b0));
      q.push_back(e_exi("rlw.E", 3'd0)); q.push_back(e_mem("rlw.Mw", 1'b0, 1'b0, 1'b0));
      q.push_back(e_rst("rlw.rst0")); q.push_back(e_rst("rlw.rst1"));
      cur_op = 6'h2b;
      q.push_back(e_fetch("rsw.F", 1'b1)); q.push_back(e_dec("rsw.D", 1'b0));
      q.push_back(e_exi("rsw.E", 3'd0)); q.push_back(e_mem("rsw.Mw", 1'b1, 1'b0, 1'b0));
      q.push_back(e_rst("rsw.rst"));
      q.push_back(e_fetch("rsw.after", 1'b0));
      run();

      // Instance b: no handshake, irq tied off, illegal op retires as NOP
      cur_sel = 1'b1; cur_op = 6'h3f;
      q.push_back(e_rst("b.rst0")); q.push_back(e_rst("b.rst1"));
      e = e_fetch("b.ill.F", 1'b1); e.rdy = 1'b0; q.push_back(e);
      e = e_dec("b.ill.D", 1'b1); e.irq = 1'b1; q.push_back(e);
      cur_op = 6'h2b;
      e = e_fetch("b.sw.F", 1'b1); e.rdy = 1'b0; q.push_back(e);
      q.push_back(e_dec("b.sw.D", 1'b0)); q.push_back(e_exi("b.sw.E", 3'd0));
      q.push_back(e_mem("b.sw.M", 1'b1, 1'b0, 1'b1));
      e = e_fetch("b.next.F", 1'b1); e.rdy = 1'b0; q.push_back(e);
      run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
